// File: rtl/clk2_word_packer.sv
// clk2_word_packer: packs BEATS single-cycle beats (first beat in the MSBs) into one wide
// word, buffers words in a 2-entry FIFO behind a valid/ready port, and raises busy early
// enough that an upstream handshake synchronizer never loses a beat.
module clk2_word_packer #(
    parameter int unsigned IN_WIDTH = 8,
    parameter int unsigned BEATS    = 4
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic                      in_valid,
    input  logic [IN_WIDTH-1:0]       in_data,
    output logic                      busy,
    output logic                      out_valid,
    output logic [IN_WIDTH*BEATS-1:0] out_data,
    input  logic                      out_ready,
    output logic                      overflow
);

    localparam int unsigned WordW = IN_WIDTH * BEATS;
    localparam int unsigned ShW   = (BEATS - 1) * IN_WIDTH;
    localparam int unsigned CntW  = $clog2(BEATS);
    localparam logic [CntW-1:0] LastBeat = CntW'(BEATS - 1);
    localparam logic [CntW-1:0] BusyBeat = CntW'(BEATS - 2);

    logic [CntW-1:0]  beat_cnt_q, beat_cnt_d;
    logic [ShW-1:0]   shift_q, shift_d;
    logic [WordW-1:0] entry_q [2];
    logic [WordW-1:0] entry_d [2];
    logic [1:0]       count_q, count_d;
    logic             overflow_q, overflow_d;

    logic [WordW-1:0] word;
    logic [1:0]       level;
    logic             complete;
    logic             pop;
    logic             push;

    // Stored beats followed by the live beat; the low part doubles as the next shift value.
    assign word     = {shift_q, in_data};
    assign complete = in_valid && (beat_cnt_q == LastBeat);
    assign pop      = (count_q != 2'd0) && out_ready;
    // A pop in the same cycle frees a slot, so a full FIFO can still accept.
    assign push     = complete && ((count_q != 2'd2) || pop);
    // Occupancy after the pop, i.e. the slot the pushed word lands in.
    assign level    = count_q - {1'b0, pop};

    // Assembler: shift beats in and count towards a complete word.
    always_comb begin
        beat_cnt_d = beat_cnt_q;
        shift_d    = shift_q;
        if (in_valid) begin
            shift_d    = word[ShW-1:0];
            beat_cnt_d = complete ? '0 : beat_cnt_q + 1'b1;
        end
    end

    // FIFO next state: pop shifts the tail to the head, push fills the first free slot.
    always_comb begin
        entry_d    = entry_q;
        count_d    = count_q - {1'b0, pop} + {1'b0, push};
        overflow_d = overflow_q | (complete && !push);
        if (pop) begin
            entry_d[0] = entry_q[1];
        end
        if (push) begin
            if (level == 2'd0) begin
                entry_d[0] = word;
            end else begin
                entry_d[1] = word;
            end
        end
    end

    // State registers with asynchronous reset discarding partial and buffered words.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            beat_cnt_q <= '0;
            shift_q    <= '0;
            entry_q[0] <= '0;
            entry_q[1] <= '0;
            count_q    <= 2'd0;
            overflow_q <= 1'b0;
        end else begin
            beat_cnt_q <= beat_cnt_d;
            shift_q    <= shift_d;
            entry_q[0] <= entry_d[0];
            entry_q[1] <= entry_d[1];
            count_q    <= count_d;
            overflow_q <= overflow_d;
        end
    end

    // Outputs decoded from registered state only.
    always_comb begin
        out_valid = (count_q != 2'd0);
        out_data  = out_valid ? entry_q[0] : '0;
        // Raised while two more beats could still complete a word into a full FIFO.
        busy      = (count_q == 2'd2) && (beat_cnt_q >= BusyBeat);
        overflow  = overflow_q;
    end

endmodule

// File: tb/tb_clk2_word_packer.sv
// Bench for clk2_word_packer: directed scenarios plus randomized traffic from a
// synchronizer-like source, checked against a queue-based reference model and a scoreboard.
module tb_clk2_word_packer;

    localparam int unsigned IW = 8;
    localparam int unsigned NB = 4;
    localparam int unsigned WW = IW * NB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [IW-1:0] in_data = '0;
    logic          out_ready = 1'b0;
    logic          busy;
    logic          out_valid;
    logic [WW-1:0] out_data;
    logic          overflow;

    clk2_word_packer #(
        .IN_WIDTH(IW),
        .BEATS   (NB)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_data  (in_data),
        .busy     (busy),
        .out_valid(out_valid),
        .out_data (out_data),
        .out_ready(out_ready),
        .overflow (overflow)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    logic [WW-1:0] sb_q[$];   // words the monitor expects to see accepted, in order
    logic [WW-1:0] mq[$];     // model of FIFO contents
    logic [IW-1:0] beats[$];  // model of the partial word
    bit            movf = 1'b0;

    task automatic chk(input string name, input logic [WW-1:0] act, input logic [WW-1:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_state();
        bit exp_busy;
        exp_busy = (mq.size() == 2) && (beats.size() >= NB - 2);
        chk("busy", WW'(busy), WW'(exp_busy));
        chk("out_valid", WW'(out_valid), WW'(mq.size() != 0));
        chk("out_data", out_data, (mq.size() != 0) ? mq[0] : '0);
        chk("overflow", WW'(overflow), WW'(movf));
    endtask

    // One cycle: check state left by the previous edge, drive new inputs, predict the next edge.
    task automatic step(input bit v, input logic [IW-1:0] d, input bit r);
        int            sz;
        bit            done;
        bit            popped;
        logic [WW-1:0] w;
        @(negedge clk);
        check_state();
        in_valid  = v;
        in_data   = d;
        out_ready = r;
        sz     = mq.size();
        popped = (sz != 0) && r;
        done   = 1'b0;
        w      = '0;
        if (v) begin
            beats.push_back(d);
            if (beats.size() == NB) begin
                foreach (beats[i]) w = (w << IW) | WW'(beats[i]);
                beats.delete();
                done = 1'b1;
            end
        end
        if (popped) void'(mq.pop_front());
        if (done) begin
            if (sz < 2 || popped) begin
                mq.push_back(w);
                sb_q.push_back(w);
            end else begin
                movf = 1'b1;
            end
        end
    endtask

    task automatic idle(input int n, input bit r);
        for (int i = 0; i < n; i++) step(1'b0, '0, r);
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        #1;
        chk("rst_busy", WW'(busy), '0);
        chk("rst_out_valid", WW'(out_valid), '0);
        chk("rst_out_data", out_data, '0);
        chk("rst_overflow", WW'(overflow), '0);
        mq.delete();
        beats.delete();
        sb_q.delete();
        movf = 1'b0;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Monitor: just before each rising edge, pop and compare every accepted word.
    logic [WW-1:0] held;
    bit            held_v = 1'b0;
    initial begin
        forever begin
            @(negedge clk);
            #4;
            if (rst) begin
                held_v = 1'b0;
            end else begin
                if (held_v) begin
                    chk("hold_valid", WW'(out_valid), WW'(1));
                    chk("hold_data", out_data, held);
                end
                if (out_valid && out_ready) begin
                    if (sb_q.size() == 0) begin
                        n_tests++;
                        n_fail++;
                        $display("FAIL spurious_word: got 0x%0h, expected no word at %0t",
                                 out_data, $time);
                    end else begin
                        chk("word", out_data, sb_q.pop_front());
                    end
                end
                held_v = out_valid && !out_ready;
                held   = out_data;
            end
        end
    end

    initial begin
        bit b_last;
        bit snd;

        // Basic packing
        do_reset();
        step(1'b1, 8'h11, 1'b1);
        step(1'b1, 8'h22, 1'b1);
        step(1'b1, 8'h33, 1'b1);
        step(1'b1, 8'h44, 1'b1);
        idle(3, 1'b1);

        // Back-to-back burst
        for (int i = 1; i <= 8; i++) step(1'b1, IW'(i), 1'b1);
        idle(3, 1'b1);
        chk("burst_drained", WW'(sb_q.size()), '0);

        // Back-pressure: busy must rise after the 10th beat, then fall after the first pop
        for (int i = 0; i < 10; i++) step(1'b1, IW'(8'h40 + i), 1'b0);
        idle(1, 1'b0);
        chk("bp_busy_high", WW'(busy), WW'(1));
        idle(4, 1'b1);
        chk("bp_busy_low", WW'(busy), '0);

        // Forced overflow: third word is dropped, first two stay intact
        do_reset();
        for (int i = 0; i < 12; i++) step(1'b1, IW'(8'h80 + i), 1'b0);
        idle(2, 1'b0);
        chk("ovf_set", WW'(overflow), WW'(1));
        chk("ovf_head", out_data, 32'h80818283);
        idle(4, 1'b1);
        chk("ovf_sticky", WW'(overflow), WW'(1));

        // Reset mid-word
        do_reset();
        step(1'b1, 8'h55, 1'b1);
        step(1'b1, 8'h66, 1'b1);
        do_reset();
        for (int i = 0; i < 4; i++) step(1'b1, IW'(8'hA0 + i), 1'b1);
        step(1'b0, '0, 1'b0);
        chk("rst_word", out_data, 32'hA0A1A2A3);
        idle(3, 1'b1);

        // Randomized source obeying a one-cycle-stale busy: slow then fast source
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            b_last = 1'b0;
            for (int c = 0; c < 1500; c++) begin
                snd = !b_last && ($urandom_range(99) < ((pass == 0) ? 25 : 90));
                step(snd, IW'($urandom), ($urandom_range(99) < 45));
                b_last = busy;
            end
            idle(6, 1'b1);
            chk("rand_no_overflow", WW'(overflow), '0);
            chk("rand_drained", WW'(sb_q.size()), '0);
        end

        idle(2, 1'b1);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
